// File: rtl/bandit_pkg.sv
// bandit_pkg: shared types and helpers for the bandit agent.
// Holds the FSM state type, LFSR defaults and the Q update rule.
package bandit_pkg;

  typedef enum logic [2:0] {
    INIT,
    DECIDING,
    FETCH,
    SCANNING,
    ACTUATING,
    OBSERVING,
    UPDATING
  } state_t;

  localparam logic [15:0] SEED_DEF = 16'hACE1;
  localparam logic [15:0] TAPS_DEF = 16'hB400;

  // Q + ((R - Q) >>> shift), one bit wider than the operands so the
  // difference never wraps; the result always lies between Q and R.
  function automatic logic signed [31:0] q_update(
    input logic signed [31:0] q,
    input logic signed [31:0] r,
    input int unsigned        shift
  );
    logic signed [32:0] qx;
    logic signed [32:0] rx;
    logic signed [32:0] d;
    logic signed [32:0] s;
    logic signed [32:0] sum;
    qx  = 33'(q);
    rx  = 33'(r);
    d   = rx - qx;
    s   = d >>> shift;
    sum = qx + s;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/bandit_agent_if.sv
// bandit_agent_if: action and reward valid/ready streams.
// master = agent side, slave = environment side.
interface bandit_agent_if #(
  parameter int ACTION_WIDTH = 8,
  parameter int REWARD_WIDTH = 8
);
  logic                    action_valid;
  logic                    action_ready;
  logic [ACTION_WIDTH-1:0] action_data;
  logic                    action_explore;
  logic                    reward_valid;
  logic                    reward_ready;
  logic [REWARD_WIDTH-1:0] reward_data;

  modport master (
    output action_valid, action_data, action_explore, reward_ready,
    input  action_ready, reward_valid, reward_data
  );

  modport slave (
    input  action_valid, action_data, action_explore, reward_ready,
    output action_ready, reward_valid, reward_data
  );
endinterface

// File: rtl/bandit_agent_lfsr.sv
// lfsr: Fibonacci LFSR, shifts left and feeds the tap parity into bit 0.
// A nonzero seed keeps it out of the all-zero lock-up state.
module lfsr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400)
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] state
);

  // Free-running shift register, reloaded with the seed on reset.
  always_ff @(posedge clock) begin
    if (reset) state <= SEED;
    else       state <= {state[WIDTH-2:0], ^(state & TAPS)};
  end

endmodule

// File: rtl/bandit_agent.sv
// bandit_agent: epsilon-greedy multi-armed bandit with a Q table.
// Greedy picks scan all arms; ties go to the lowest index.
module bandit_agent
  import bandit_pkg::*;
#(
  parameter int ACTION_WIDTH = 8,
  parameter int VALUE_WIDTH  = 16,
  parameter int REWARD_WIDTH = 8,
  parameter int ALPHA_SHIFT  = 3,
  parameter int EPSILON      = 16,
  parameter int LFSR_WIDTH   = 16,
  parameter logic [LFSR_WIDTH-1:0] SEED = LFSR_WIDTH'(SEED_DEF),
  parameter logic [LFSR_WIDTH-1:0] TAPS = LFSR_WIDTH'(TAPS_DEF),
  parameter int INIT_VALUE   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  bandit_agent_if.master        bus,
  output logic                  busy
);

  localparam int N  = 1 << ACTION_WIDTH;
  localparam int CW = ACTION_WIDTH + 1;

  typedef logic signed [VALUE_WIDTH-1:0] q_t;

  state_t                         state, state_n;
  logic [CW-1:0]                  cnt;
  logic [LFSR_WIDTH-1:0]          rnd;
  q_t                             q_tab [N];
  q_t                             rd_data;
  q_t                             best_value;
  q_t                             action_value;
  logic [ACTION_WIDTH-1:0]        rd_idx;
  logic [ACTION_WIDTH-1:0]        best_index;
  logic [ACTION_WIDTH-1:0]        action_index;
  logic                           best_valid;
  logic                           explore;
  logic signed [REWARD_WIDTH-1:0] reward_q;
  logic                           explore_pick;
  logic                           take;
  logic                           last_init;
  logic                           last_scan;
  logic                           act_fire;
  logic                           rew_fire;
  logic                           we;
  logic [ACTION_WIDTH-1:0]        wa;
  q_t                             wd;
  logic signed [31:0]             q_new;
  logic                           unused_bits;

  lfsr #(
    .WIDTH (LFSR_WIDTH),
    .SEED  (SEED),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .state (rnd)
  );

  assign explore_pick = 9'(EPSILON) > {1'b0, rnd[7:0]};
  assign take         = !best_valid || (rd_data > best_value);
  assign last_init    = cnt == CW'(N - 1);
  assign last_scan    = cnt == CW'(N);
  assign act_fire     = (state == ACTUATING) && bus.action_ready;
  assign rew_fire     = (state == OBSERVING) && bus.reward_valid;
  assign q_new        = q_update(32'(action_value), 32'(reward_q),
                                 ALPHA_SHIFT);
  assign we           = (state == INIT) || (state == UPDATING);
  assign wa           = (state == INIT) ? cnt[ACTION_WIDTH-1:0]
                                        : action_index;
  assign wd           = (state == INIT) ? VALUE_WIDTH'(INIT_VALUE)
                                        : q_new[VALUE_WIDTH-1:0];
  assign unused_bits  = ^{rnd, q_new};

  assign bus.action_valid   = state == ACTUATING;
  assign bus.reward_ready   = state == OBSERVING;
  assign bus.action_data    = action_index;
  assign bus.action_explore = explore;
  assign busy = !((state == ACTUATING) || (state == OBSERVING));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= INIT;
    else       state <= state_n;
  end

  // Next-state decode for one decide/act/observe/update round.
  always_comb begin
    state_n = state;
    unique case (state)
      INIT:      if (last_init) state_n = DECIDING;
      DECIDING:  state_n = explore_pick ? FETCH : SCANNING;
      FETCH:     state_n = ACTUATING;
      SCANNING:  if (last_scan) state_n = ACTUATING;
      ACTUATING: if (act_fire) state_n = OBSERVING;
      OBSERVING: if (rew_fire) state_n = UPDATING;
      UPDATING:  state_n = DECIDING;
      default:   state_n = INIT;
    endcase
  end

  // Table write port and the one-cycle-latency scan read.
  always_ff @(posedge clock) begin
    if (we) q_tab[wa] <= wd;
    rd_data <= q_tab[cnt[ACTION_WIDTH-1:0]];
  end

  // Round datapath: counters, argmax tracking and latched action/reward.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt          <= '0;
      rd_idx       <= '0;
      best_index   <= '0;
      best_value   <= '0;
      best_valid   <= 1'b0;
      action_index <= '0;
      action_value <= '0;
      explore      <= 1'b0;
      reward_q     <= '0;
    end else begin
      unique case (state)
        INIT: cnt <= last_init ? '0 : cnt + 1'b1;
        DECIDING: begin
          cnt <= '0;
          if (explore_pick) begin
            action_index <= rnd[ACTION_WIDTH-1:0];
            explore      <= 1'b1;
          end else begin
            best_index <= '0;
            best_valid <= 1'b0;
          end
        end
        FETCH: action_value <= q_tab[action_index];
        SCANNING: begin
          cnt    <= last_scan ? '0 : cnt + 1'b1;
          rd_idx <= cnt[ACTION_WIDTH-1:0];
          if (cnt != '0 && take) begin
            best_value <= rd_data;
            best_index <= rd_idx;
            best_valid <= 1'b1;
          end
          if (last_scan) begin
            action_index <= take ? rd_idx : best_index;
            action_value <= take ? rd_data : best_value;
            explore      <= 1'b0;
          end
        end
        OBSERVING: if (rew_fire) reward_q <= signed'(bus.reward_data);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bandit_agent.sv
// tb_bandit_agent: greedy and always-explore agents against a
// behavioural Q-table / LFSR model.
module tb_bandit_agent;

  logic clock;
  logic rst0;
  logic rst1;
  logic busy0;
  logic busy1;

  int errors = 0;
  int checks = 0;
  int q [4];
  int cur;

  bandit_agent_if #(.ACTION_WIDTH(2), .REWARD_WIDTH(8)) if0 ();
  bandit_agent_if #(.ACTION_WIDTH(2), .REWARD_WIDTH(8)) if1 ();

  bandit_agent #(.ACTION_WIDTH(2), .EPSILON(0)) dut0 (
    .clock (clock),
    .reset (rst0),
    .bus   (if0),
    .busy  (busy0)
  );

  bandit_agent #(.ACTION_WIDTH(2), .EPSILON(256)) dut1 (
    .clock (clock),
    .reset (rst1),
    .bus   (if1),
    .busy  (busy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fdiv(input int d, input int s);
    int p;
    p = 1 << s;
    if (d >= 0) return d / p;
    return -((-d + p - 1) / p);
  endfunction

  function automatic int greedy();
    int b;
    b = 0;
    for (int i = 1; i < 4; i++)
      if (q[i] > q[b]) b = i;
    return b;
  endfunction

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic wait_av(output int lat);
    lat = 0;
    while (!if0.action_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) q[i] = 0;
    cur = greedy();
  endtask

  // Called with dut0 presenting an action; rewards it, checks next pick.
  task automatic round(input int r);
    int lat;
    if0.reward_valid = 1'b1;
    if0.reward_data  = 8'(r);
    tick();
    check("reward_ready", int'(if0.reward_ready), 1);
    tick();
    if0.reward_valid = 1'b0;
    q[cur] = q[cur] + fdiv(r - q[cur], 3);
    cur = greedy();
    wait_av(lat);
    check("round_latency", lat, 7);
    check("greedy_arm", int'(if0.action_data), cur);
    check("greedy_explore", int'(if0.action_explore), 0);
  endtask

  logic [15:0] lf [64];

  initial begin
    int lat;
    int c;
    int t;
    logic [1:0] a0;

    rst0 = 1'b1;
    rst1 = 1'b1;
    if0.action_ready = 1'b1;
    if0.reward_valid = 1'b0;
    if0.reward_data  = '0;
    if1.action_ready = 1'b1;
    if1.reward_valid = 1'b1;
    if1.reward_data  = '0;
    repeat (3) tick();

    check("rst_action_valid", int'(if0.action_valid), 0);
    check("rst_action_data", int'(if0.action_data), 0);
    check("rst_action_explore", int'(if0.action_explore), 0);
    check("rst_reward_ready", int'(if0.reward_ready), 0);
    check("rst_busy", int'(busy0), 1);

    rst0 = 1'b0;
    model_reset();
    wait_av(lat);
    check("startup_latency", lat, 10);
    check("startup_arm", int'(if0.action_data), cur);
    check("startup_explore", int'(if0.action_explore), 0);
    check("startup_busy", int'(busy0), 0);

    round(80);
    round(-128);
    check("q0_after_neg", q[0], -8);
    round(120);
    round(5);

    if0.action_ready = 1'b0;
    if0.reward_valid = 1'b1;
    if0.reward_data  = 8'd127;
    a0 = if0.action_data;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_valid", int'(if0.action_valid), 1);
      check("bp_data", int'(if0.action_data), cur);
      check("bp_reward_ready", int'(if0.reward_ready), 0);
    end
    check("bp_stable", int'(if0.action_data), int'(a0));
    if0.reward_valid = 1'b0;
    if0.action_ready = 1'b1;
    round(-40);

    repeat (20) round(int'($urandom_range(255)) - 128);

    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    model_reset();
    wait_av(lat);
    check("rerun_latency", lat, 10);
    round(-128);
    round(-128);
    round(80);
    check("arm2_pick", cur, 2);
    tick();
    check("obs_reward_ready", int'(if0.reward_ready), 1);
    rst0 = 1'b1;
    tick();
    check("midrst_busy", int'(busy0), 1);
    check("midrst_reward_ready", int'(if0.reward_ready), 0);
    check("midrst_valid", int'(if0.action_valid), 0);
    rst0 = 1'b0;
    model_reset();
    wait_av(lat);
    check("reinit_latency", lat, 10);
    check("reinit_arm", int'(if0.action_data), 0);
    round(0);

    lf[0] = 16'hACE1;
    for (int i = 1; i < 64; i++) lf[i] = lstep(lf[i-1]);
    rst1 = 1'b0;
    c = 0;
    for (int k = 0; k < 8; k++) begin
      t = 6 + 5 * k;
      if1.reward_data = 8'($urandom_range(255));
      while (c < t - 1) begin
        tick();
        c++;
      end
      check("explore_pre_valid", int'(if1.action_valid), 0);
      tick();
      c++;
      check("explore_valid", int'(if1.action_valid), 1);
      check("explore_flag", int'(if1.action_explore), 1);
      check("explore_arm", int'(if1.action_data), int'(lf[t-2][1:0]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bandit_agent.md
Name: bandit_agent

Overview:
- Parametrised epsilon-greedy multi-armed bandit agent with 2^ACTION_WIDTH arms.
- Holds one signed action-value Q(a) per arm in an internal table.
- Each round it either exploits or explores:
  - Exploit: a full sequential argmax scan over all arms.
  - Explore: a pseudorandom arm, chosen with probability EPSILON/256.
- Emits the chosen arm on a valid/ready action stream, accepts the reward on a valid/ready reward stream, then updates Q(a) += (R - Q(a)) >>> ALPHA_SHIFT.
- Sits between the environment front-end (action sink, reward source) and system control.

Parameters:
- ACTION_WIDTH, 8: arm index width; N = 2^ACTION_WIDTH arms.
- VALUE_WIDTH, 16: signed Q width.
- REWARD_WIDTH, 8: signed reward width; must be <= VALUE_WIDTH.
- ALPHA_SHIFT, 3: step size alpha = 2^-ALPHA_SHIFT; range 0..VALUE_WIDTH.
- EPSILON, 16: explore threshold, range 0..256 (0 = never explore, 256 = always explore).
- LFSR_WIDTH, 16: pseudorandom generator width; must be >= max(8, ACTION_WIDTH).
- SEED, 16'hACE1: LFSR reset value; must be nonzero.
- TAPS, 16'hB400: Fibonacci feedback tap mask.
- INIT_VALUE, 0: Q value written to every arm at initialisation (optimistic init when > 0).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- action_valid  out  1  chosen arm is available
- action_ready  in  1  downstream accepts the action
- action_data  out  ACTION_WIDTH  chosen arm index
- action_explore  out  1  qualifies action_data: 1 = exploratory pick, 0 = greedy pick
- reward_valid  in  1  reward is available
- reward_ready  out  1  agent accepts the reward
- reward_data  in  REWARD_WIDTH  signed reward for the last action
- busy  out  1  high in every state except ACTUATING and OBSERVING

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Reset forces state INIT, arm counter 0, LFSR = SEED.
  - Reset values: action_valid=0, action_data=0, action_explore=0, reward_ready=0, busy=1.
  - Reset in any state (including mid-scan or mid-handshake) abandons the round, re-initialises the whole table and discards any in-flight reward.
- States: INIT, DECIDING, FETCH, SCANNING, ACTUATING, OBSERVING, UPDATING.
- INIT:
  - Writes INIT_VALUE to arm k on cycle k, for k = 0..N-1; N cycles total.
  - Then goes to DECIDING.
- DECIDING (1 cycle):
  - Samples the LFSR.
  - If EPSILON > lfsr[7:0]: explore. Latch index = lfsr[ACTION_WIDTH-1:0], explore=1, go to FETCH.
  - Else: exploit. Clear best (best_index=0, best_valid=0), go to SCANNING.
- FETCH (1 cycle): registers Q(index) into action_value, then goes to ACTUATING.
- SCANNING (N+1 cycles):
  - Table read has 1-cycle latency. The read address steps 0..N-1; compares are pipelined one cycle behind the reads.
  - Candidate replaces best if best_valid=0 or Q > best (strict signed compare). Ties therefore resolve to the lowest index.
  - After the last compare: action_index = best_index, action_value = best value, explore=0, go to ACTUATING.
- ACTUATING:
  - action_valid=1; action_data and action_explore are held stable until the handshake.
  - On action_valid & action_ready, go to OBSERVING.
  - Exactly one action is issued per round.
- OBSERVING:
  - reward_ready=1.
  - On reward_valid & reward_ready, register the reward and go to UPDATING.
  - reward_valid asserted in any other state is ignored and not buffered.
- UPDATING (1 cycle):
  - Sign-extend R to VALUE_WIDTH+1 bits.
  - d = R - Q, computed at VALUE_WIDTH+1 bits.
  - Q' = Q + (d >>>ALPHA_SHIFT), with arithmetic (floor) shift.
  - Write Q' to action_index, then go to DECIDING.
  - Q' always lies between Q and R, so it always fits VALUE_WIDTH; no saturation logic is needed.
- LFSR: advances every cycle including INIT; never reaches all-zero.
- Round latency with no backpressure:
  - Exploit round: 1 + (N+1) cycles to action_valid.
  - Explore round: 2 cycles to action_valid.
  - First action after reset release: N + 1 + (N+1) cycles.
- Simultaneous action and reward handshakes cannot occur, because the two ready/valid signals are state-exclusive.

Decomposition:
- bandit_pkg holds:
  - the state_t enum;
  - the update function q_update(q, r, shift) with sign extension;
  - the default SEED/TAPS constants.
- One sub-module: lfsr (parameters WIDTH, SEED, TAPS; ports clock, reset, state out). It is reused elsewhere in the codebase.

Test Plan:
- Common setting for all scenarios unless stated: ACTION_WIDTH=2 (N=4), EPSILON=0, action_ready=1.
- Startup timing: release reset -> action_valid first high on cycle 10 (INIT 4 + DECIDING 1 + SCANNING 5), action_data=0, action_explore=0, busy=0.
- Update arithmetic (INIT_VALUE=0, ALPHA_SHIFT=3):
  - Reward 80 on arm 0 -> Q(0)=10.
  - Next reward -128 on arm 0 -> Q(0) = 10 + floor(-138/8) = -8.
  - Check via next greedy pick: arm 1, since Q(0) < 0 and arms 1..3 remain 0.
- Greedy tracking: reward arm 0 with 80, then reward arm 1 with 120 -> subsequent actions are always arm 1 (Q=15); a tie between equal positive arms picks the lower index.
- Backpressure:
  - Hold action_ready=0 for 20 cycles -> action_valid stays 1, action_data stable.
  - reward_valid=1 during ACTUATING -> reward_ready=0 and the table is unchanged.
- Always explore (EPSILON=256): every action has action_explore=1 and action_data equals the reference-model LFSR[1:0] sampled in DECIDING; action_valid appears 2 cycles after DECIDING.
- Reset in OBSERVING after Q(2) was raised -> INIT reruns, all Q return to INIT_VALUE, first action again on cycle 10 with action_data=0.
